// File: rtl/pc_stack_unit_pkg.sv
// Shared operation encodings and default sizes for the program-counter/return-stack unit.
// The return stack is built only when PCU_RET_STACK_EN is defined.
package pcu_pkg;

    localparam int ADDR_W_DEF      = 16;
    localparam int OFFS_W_DEF      = 8;
    localparam int STACK_DEPTH_DEF = 8;

    typedef enum logic [2:0] {
        OP_NEXT   = 3'd0,
        OP_JUMP   = 3'd1,
        OP_BRANCH = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4,
        OP_HOLD   = 3'd5
    } op_e;

    // Width needed to count 0..depth inclusive.
    function automatic int depth_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pc_stack_unit_if.sv
// Sequencer command/status bundle for pc_stack_unit; master drives commands, slave is the unit.
interface pc_stack_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int OFFS_W  = 8,
    parameter int DEPTH_W = 4
);
    logic                en;
    logic [2:0]          op;
    logic                cond;
    logic [ADDR_W-1:0]   target;
    logic [OFFS_W-1:0]   offset;
    logic [ADDR_W-1:0]   pc;
    logic [DEPTH_W-1:0]  depth;
    logic                stack_full;
    logic                stack_empty;
    logic                ovf_err;
    logic                unf_err;

    modport master (
        output en, op, cond, target, offset,
        input  pc, depth, stack_full, stack_empty, ovf_err, unf_err
    );

    modport slave (
        input  en, op, cond, target, offset,
        output pc, depth, stack_full, stack_empty, ovf_err, unf_err
    );
endinterface

// File: rtl/pc_stack_unit_ret_stack.sv
// LIFO of return addresses; depth alone marks which entries are valid, so storage is never cleared.
module ret_stack
    import pcu_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic                               clk,
    input  logic                               clear,
    input  logic                               push,
    input  logic                               pop,
    input  logic [ADDR_W-1:0]                  din,
    output logic [ADDR_W-1:0]                  top,
    output logic [depth_w(STACK_DEPTH)-1:0]    depth
);
    localparam int DEPTH_W = depth_w(STACK_DEPTH);
    localparam int PTR_W   = $clog2(STACK_DEPTH);

    logic [ADDR_W-1:0]  mem_q [STACK_DEPTH];
    logic [ADDR_W-1:0]  mem_d [STACK_DEPTH];
    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;
    logic [DEPTH_W-1:0] top_ptr_s;
    logic               full_s;
    logic               empty_s;

    // Push/pop bookkeeping; overflow and underflow requests are ignored here.
    always_comb begin
        full_s    = (depth_q == DEPTH_W'(STACK_DEPTH));
        empty_s   = (depth_q == {DEPTH_W{1'b0}});
        depth_d   = depth_q;
        mem_d     = mem_q;
        top_ptr_s = {DEPTH_W{1'b0}};
        if (!empty_s) begin
            top_ptr_s = depth_q - DEPTH_W'(1);
        end else begin
            top_ptr_s = {DEPTH_W{1'b0}};
        end
        if (push && !full_s) begin
            mem_d[depth_q[PTR_W-1:0]] = din;
            depth_d = depth_q + DEPTH_W'(1);
        end else if (pop && !empty_s) begin
            depth_d = depth_q - DEPTH_W'(1);
        end else begin
            depth_d = depth_q;
        end
    end

    // Occupancy register with clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            depth_q <= {DEPTH_W{1'b0}};
        end else begin
            depth_q <= depth_d;
        end
    end

    // Entry storage, deliberately without reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign top   = mem_q[top_ptr_s[PTR_W-1:0]];
    assign depth = depth_q;

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with jump/branch/call/return; define PCU_RET_STACK_EN to build the return stack,
// otherwise CALL acts as JUMP and RET as NEXT.
module pc_stack_unit
    import pcu_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter int                OFFS_W       = OFFS_W_DEF,
    parameter int                STACK_DEPTH  = STACK_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = {ADDR_W{1'b0}}
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pc_reset,
    pc_stack_unit_if.slave bus
);
    localparam int DEPTH_W = depth_w(STACK_DEPTH);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic [ADDR_W-1:0]  pc_inc_s;
    logic [ADDR_W-1:0]  pc_branch_s;
    logic [OFFS_W-1:0]  offset_s;
    logic [DEPTH_W-1:0] depth_s;
    logic               clear_s;

    assign clear_s  = reset | pc_reset;
    assign offset_s = bus.offset;

`ifdef PCU_RET_STACK_EN
    logic               push_s;
    logic               pop_s;
    logic [ADDR_W-1:0]  stack_top_s;

    ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .clear (clear_s),
        .push  (push_s),
        .pop   (pop_s),
        .din   (pc_inc_s),
        .top   (stack_top_s),
        .depth (depth_s)
    );
`else
    assign depth_s = {DEPTH_W{1'b0}};
`endif

    // Next-PC and sticky error decode for the sampled operation.
    always_comb begin
        pc_inc_s    = pc_q + ADDR_W'(1);
        pc_branch_s = pc_q + ADDR_W'($signed(offset_s));
        pc_d        = pc_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
`ifdef PCU_RET_STACK_EN
        push_s      = 1'b0;
        pop_s       = 1'b0;
`endif
        if (bus.en) begin
            case (bus.op)
                OP_NEXT:   pc_d = pc_inc_s;
                OP_JUMP:   pc_d = bus.target;
                OP_BRANCH: pc_d = bus.cond ? pc_branch_s : pc_inc_s;
`ifdef PCU_RET_STACK_EN
                OP_CALL: begin
                    if (depth_s != DEPTH_W'(STACK_DEPTH)) begin
                        push_s = 1'b1;
                        pc_d   = bus.target;
                    end else begin
                        ovf_d  = 1'b1;
                    end
                end
                OP_RET: begin
                    if (depth_s != {DEPTH_W{1'b0}}) begin
                        pop_s = 1'b1;
                        pc_d  = stack_top_s;
                    end else begin
                        pc_d  = pc_inc_s;
                        unf_d = 1'b1;
                    end
                end
`else
                OP_CALL:   pc_d = bus.target;
                OP_RET:    pc_d = pc_inc_s;
`endif
                OP_HOLD:   pc_d = pc_q;
                default:   pc_d = pc_q;
            endcase
        end else begin
            pc_d = pc_q;
        end
    end

    // Architectural state; either reset source discards the cycle's operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_VECTOR;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (pc_reset) begin
            pc_q  <= RESET_VECTOR;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.depth       = depth_s;
    assign bus.stack_full  = (depth_s == DEPTH_W'(STACK_DEPTH));
    assign bus.stack_empty = (depth_s == {DEPTH_W{1'b0}});
    assign bus.ovf_err     = ovf_q;
    assign bus.unf_err     = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: queue-based reference model checked every cycle plus literal
// expectations; covers both the PCU_RET_STACK_EN build and the default build.
module tb_pc_stack_unit;
    import pcu_pkg::*;

    localparam int AW = 16;
    localparam int OW = 8;
    localparam int SD = 8;
    localparam int DW = 4;
`ifdef PCU_RET_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic pc_reset = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    int   m_pc     = 0;
    int   m_stk[$];
    bit   m_ovf    = 1'b0;
    bit   m_unf    = 1'b0;
    bit   chk_on   = 1'b0;

    pc_stack_unit_if #(.ADDR_W(AW), .OFFS_W(OW), .DEPTH_W(DW)) bus ();
    pc_stack_unit_if #(.ADDR_W(AW), .OFFS_W(OW), .DEPTH_W(DW)) bus2 ();

    pc_stack_unit #(.ADDR_W(AW), .OFFS_W(OW), .STACK_DEPTH(SD), .RESET_VECTOR(16'h0000)) dut (
        .clk(clk), .reset(reset), .pc_reset(pc_reset), .bus(bus.slave));

    pc_stack_unit #(.ADDR_W(AW), .OFFS_W(OW), .STACK_DEPTH(SD), .RESET_VECTOR(16'h0100)) dut2 (
        .clk(clk), .reset(reset), .pc_reset(pc_reset), .bus(bus2.slave));

    assign bus2.en     = bus.en;
    assign bus2.op     = bus.op;
    assign bus2.cond   = bus.cond;
    assign bus2.target = bus.target;
    assign bus2.offset = bus.offset;

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one step per rising edge, from the operation rules.
    always @(posedge clk) begin
        if (reset || pc_reset) begin
            m_pc = 0;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (bus.en) begin
            case (int'(bus.op))
                0: m_pc = (m_pc + 1) & 32'hFFFF;
                1: m_pc = int'(bus.target);
                2: m_pc = bus.cond ? ((m_pc + int'($signed(bus.offset))) & 32'hFFFF)
                                   : ((m_pc + 1) & 32'hFFFF);
                3: begin
                    if (!STK) m_pc = int'(bus.target);
                    else if (m_stk.size() < SD) begin
                        m_stk.push_back((m_pc + 1) & 32'hFFFF);
                        m_pc = int'(bus.target);
                    end else m_ovf = 1'b1;
                end
                4: begin
                    if (STK && m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else begin
                        m_pc = (m_pc + 1) & 32'hFFFF;
                        if (STK) m_unf = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            cmp("pc",    int'(bus.pc),          m_pc);
            cmp("depth", int'(bus.depth),       m_stk.size());
            cmp("full",  int'(bus.stack_full),  int'(m_stk.size() == SD));
            cmp("empty", int'(bus.stack_empty), int'(m_stk.size() == 0));
            cmp("ovf",   int'(bus.ovf_err),     int'(m_ovf));
            cmp("unf",   int'(bus.unf_err),     int'(m_unf));
        end
    end

    task automatic cyc(input bit e, input logic [2:0] o, input logic c,
                       input logic [15:0] t, input logic [7:0] off);
        bus.en     = e;
        bus.op     = o;
        bus.cond   = c;
        bus.target = t;
        bus.offset = off;
        @(posedge clk);
        #1;
    endtask

    task automatic jmp(input logic [15:0] t);
        cyc(1'b1, 3'd1, 1'b0, t, 8'h00);
    endtask

    initial begin
        bus.en = 1'b0; bus.op = 3'd0; bus.cond = 1'b0; bus.target = 16'h0000; bus.offset = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset  = 1'b0;
        chk_on = 1'b1;
        cmp("rst_pc", int'(bus.pc), 0);
        cmp("rst_depth", int'(bus.depth), 0);
        cmp("rst_empty", int'(bus.stack_empty), 1);
        cmp("rst_full", int'(bus.stack_full), 0);
        cmp("rst_vec_pc", int'(bus2.pc), 16'h0100);

        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1, 3'd0, 1'b0, 16'h0000, 8'h00);
            cmp("next_seq", int'(bus.pc), i);
            if (i == 1) cmp("rst_vec_next", int'(bus2.pc), 16'h0101);
        end
        cyc(1'b0, 3'd0, 1'b0, 16'h0000, 8'h00);
        cmp("en_low_hold", int'(bus.pc), 3);
        cyc(1'b1, 3'd5, 1'b0, 16'h1234, 8'h00);
        cmp("op_hold", int'(bus.pc), 3);
        cyc(1'b1, 3'd7, 1'b1, 16'h1234, 8'h00);
        cmp("op_undef", int'(bus.pc), 3);

        jmp(16'hFFFF);
        cmp("jump", int'(bus.pc), 16'hFFFF);
        cyc(1'b1, 3'd0, 1'b0, 16'h0000, 8'h00);
        cmp("next_wrap", int'(bus.pc), 0);

        jmp(16'h0010);
        cyc(1'b1, 3'd2, 1'b1, 16'h0000, 8'hF0);
        cmp("branch_neg", int'(bus.pc), 0);
        jmp(16'h0010);
        cyc(1'b1, 3'd2, 1'b0, 16'h0000, 8'hF0);
        cmp("branch_nt", int'(bus.pc), 16'h0011);
        cyc(1'b1, 3'd2, 1'b1, 16'h0000, 8'h7F);
        cmp("branch_pos", int'(bus.pc), 16'h0090);

        jmp(16'h0020);
        cyc(1'b1, 3'd3, 1'b0, 16'h0400, 8'h00);
        cmp("call_pc", int'(bus.pc), 16'h0400);
        cmp("call_depth", int'(bus.depth), STK ? 1 : 0);
        cyc(1'b1, 3'd4, 1'b0, 16'h0000, 8'h00);
        cmp("ret_pc", int'(bus.pc), STK ? 16'h0021 : 16'h0401);
        cmp("ret_empty", int'(bus.stack_empty), 1);

        jmp(16'h0100);
        for (int i = 0; i < SD; i++) begin
            cyc(1'b1, 3'd3, 1'b0, 16'h1000 + 16'(i * 256), 8'h00);
        end
        cmp("fill_full", int'(bus.stack_full), STK ? 1 : 0);
        cyc(1'b1, 3'd3, 1'b0, 16'h2000, 8'h00);
        cmp("ovf_pc", int'(bus.pc), STK ? 16'h1700 : 16'h2000);
        cmp("ovf_flag", int'(bus.ovf_err), STK ? 1 : 0);
        for (int i = 0; i < SD; i++) begin
            cyc(1'b1, 3'd4, 1'b0, 16'h0000, 8'h00);
            if (i == 0) cmp("lifo_first", int'(bus.pc), STK ? 16'h1601 : 16'h2001);
        end
        cmp("lifo_last", int'(bus.pc), STK ? 16'h0101 : 16'h2008);
        cmp("ovf_sticky", int'(bus.ovf_err), STK ? 1 : 0);

        jmp(16'h0005);
        cyc(1'b1, 3'd4, 1'b0, 16'h0000, 8'h00);
        cmp("unf_pc", int'(bus.pc), 16'h0006);
        cmp("unf_flag", int'(bus.unf_err), STK ? 1 : 0);
        pc_reset = 1'b1;
        cyc(1'b1, 3'd0, 1'b0, 16'h0000, 8'h00);
        pc_reset = 1'b0;
        cmp("pcrst_pc", int'(bus.pc), 0);
        cmp("pcrst_unf", int'(bus.unf_err), 0);
        cmp("pcrst_ovf", int'(bus.ovf_err), 0);

        jmp(16'h0030);
        cyc(1'b1, 3'd3, 1'b0, 16'h0300, 8'h00);
        pc_reset = 1'b1;
        cyc(1'b1, 3'd3, 1'b0, 16'h0400, 8'h00);
        pc_reset = 1'b0;
        cmp("pcrst_call_pc", int'(bus.pc), 0);
        cmp("pcrst_call_depth", int'(bus.depth), 0);

        cyc(1'b1, 3'd3, 1'b0, 16'h0500, 8'h00);
        reset = 1'b1;
        cyc(1'b1, 3'd3, 1'b0, 16'h0600, 8'h00);
        reset = 1'b0;
        cmp("rst_mid_pc", int'(bus.pc), 0);
        cmp("rst_mid_depth", int'(bus.depth), 0);
        cmp("rst_mid_vec", int'(bus2.pc), 16'h0100);

        cyc(1'b1, 3'd0, 1'b0, 16'h0000, 8'h00);
        cyc(1'b0, 3'd0, 1'b0, 16'h0000, 8'h00);
        @(negedge clk);
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
